// File: rtl/line_follower_ctrl.sv
// rtl/line_follower_ctrl.sv - line-follower drive FSM with period-synchronised dual PWM motor enables
module line_follower_ctrl #(
  parameter int PWM_BITS    = 8,
  parameter int DUTY_FAST   = 200,
  parameter int DUTY_SLOW   = 80,
  parameter int LOST_CYCLES = 1000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [2:0] Sensor,
  output logic       LeftPwm,
  output logic       RightPwm,
  output logic [2:0] State,
  output logic       Lost
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FORWARD = 3'd1,
    LEFT    = 3'd2,
    RIGHT   = 3'd3,
    SEARCH  = 3'd4,
    HALT    = 3'd5
  } state_t;

  localparam int LC_W  = (LOST_CYCLES > 1) ? $clog2(LOST_CYCLES) : 1;
  localparam int MAX_D = (1 << PWM_BITS) - 1;
  localparam logic [PWM_BITS-1:0] FAST = PWM_BITS'((DUTY_FAST > MAX_D) ? MAX_D : DUTY_FAST);
  localparam logic [PWM_BITS-1:0] SLOW = PWM_BITS'((DUTY_SLOW > MAX_D) ? MAX_D : DUTY_SLOW);
  localparam logic [LC_W-1:0]     LOST_LAST = LC_W'(LOST_CYCLES - 1);

  state_t              state_q, state_d, cur;
  logic [PWM_BITS-1:0] pwm_cnt, duty_l, duty_r, tgt_l, tgt_r;
  logic [LC_W-1:0]     lost_cnt_q, lost_cnt_d;
  logic                last_turn_q, last_turn_d, lost_q, lost_d, lost_hit;

  // Unreachable encodings behave as IDLE.
  always_comb begin
    case (state_q)
      FORWARD, LEFT, RIGHT, SEARCH, HALT: cur = state_q;
      default:                            cur = IDLE;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    lost_d      = lost_q;
    last_turn_d = last_turn_q;
    lost_hit    = 1'b0;
    if (!Enable) begin
      state_d = IDLE;
      lost_d  = 1'b0;
    end else if (lost_q) begin
      state_d = IDLE;
    end else if (cur == HALT) begin
      state_d = HALT;
    end else if (cur == SEARCH && Sensor == 3'b000 && lost_cnt_q == LOST_LAST) begin
      state_d  = IDLE;
      lost_d   = 1'b1;
      lost_hit = 1'b1;
    end else begin
      case (Sensor)
        3'b010: state_d = FORWARD;
        3'b100, 3'b110: begin
          state_d     = LEFT;
          last_turn_d = 1'b0;
        end
        3'b001, 3'b011: begin
          state_d     = RIGHT;
          last_turn_d = 1'b1;
        end
        3'b111: state_d = HALT;
        3'b000: state_d = SEARCH;
        default: state_d = (cur == IDLE) ? FORWARD : cur;
      endcase
    end
  end

  // Counter saturates so an ambiguous 101 reading cannot push it past the limit.
  always_comb begin
    lost_cnt_d = '0;
    if (Enable && !lost_hit && cur == SEARCH)
      lost_cnt_d = (lost_cnt_q == LOST_LAST) ? lost_cnt_q : lost_cnt_q + 1'b1;
  end

  always_comb begin
    tgt_l = '0;
    tgt_r = '0;
    case (cur)
      FORWARD: begin tgt_l = FAST; tgt_r = FAST; end
      LEFT:    begin tgt_l = SLOW; tgt_r = FAST; end
      RIGHT:   begin tgt_l = FAST; tgt_r = SLOW; end
      SEARCH: begin
        tgt_l = last_turn_q ? SLOW : '0;
        tgt_r = last_turn_q ? '0 : SLOW;
      end
      default: begin tgt_l = '0; tgt_r = '0; end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      pwm_cnt     <= '0;
      duty_l      <= '0;
      duty_r      <= '0;
      lost_cnt_q  <= '0;
      last_turn_q <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwm_cnt     <= pwm_cnt + 1'b1;
      lost_cnt_q  <= lost_cnt_d;
      last_turn_q <= last_turn_d;
      lost_q      <= lost_d;
      // Stops bypass the period boundary; everything else waits for the wrap.
      if (state_d == IDLE || state_d == HALT) begin
        duty_l <= '0;
        duty_r <= '0;
      end else if (pwm_cnt == '1) begin
        duty_l <= tgt_l;
        duty_r <= tgt_r;
      end
    end
  end

  assign LeftPwm  = pwm_cnt < duty_l;
  assign RightPwm = pwm_cnt < duty_r;
  assign State    = state_q;
  assign Lost     = lost_q;

endmodule

// File: doc/line_follower_ctrl.md
# line_follower_ctrl

Steering controller that sits directly downstream of the 3-channel sensor debouncer. It consumes the three debounced line-sensor bits and runs a drive state machine (forward / steer left / steer right / search / halt). It produces two PWM motor-enable signals for the left and right wheel drivers. Duty changes are synchronised to PWM period boundaries so no runt pulses reach the motor bridge.

## Interface
- PWM_BITS, 8, width of free-running PWM counter; period = 2^PWM_BITS cycles
- DUTY_FAST, 200, high cycles per period for the outer/straight wheel
- DUTY_SLOW, 80, high cycles per period for the inner wheel when steering or searching
- LOST_CYCLES, 1000, consecutive SEARCH cycles before declaring the line lost (>=2)
- Clock  input  1  single system clock, rising edge
- Reset  input  1  asynchronous, active-low; all registers clear while low
- Enable  input  1  run request; 0 forces IDLE
- Sensor  input  3  debounced sensors, 1 = line under sensor; [2]=left, [1]=centre, [0]=right
- LeftPwm  output  1  left motor enable, PwmCnt < DutyL
- RightPwm  output  1  right motor enable, PwmCnt < DutyR
- State  output  3  current state encoding
- Lost  output  1  sticky line-lost flag

## Operation
- States: IDLE=0, FORWARD=1, LEFT=2, RIGHT=3, SEARCH=4, HALT=5. Codes 6/7 are unreachable and decode to IDLE.
- Enable=0, from any state: next state IDLE, Lost cleared, LostCnt cleared.
- Enable=1 and Lost=0, from IDLE/FORWARD/LEFT/RIGHT/SEARCH, decode Sensor:
  - 010 → FORWARD.
  - 100 or 110 → LEFT, LastTurn<=0.
  - 001 or 011 → RIGHT, LastTurn<=1.
  - 111 → HALT (stop line).
  - 000 → SEARCH.
  - 101 → hold current state. From IDLE, go to FORWARD.
- HALT is sticky until Enable=0. Sensor is ignored in HALT.
- Enable=1 with Lost=1 → stay IDLE.
- LostCnt:
  - Increments each cycle spent in SEARCH; cleared on any other state.
  - In SEARCH with Sensor=000 and LostCnt==LOST_CYCLES-1 → next IDLE, Lost<=1, LostCnt<=0.
  - A non-000 Sensor in the same cycle wins: normal decode applies and Lost stays 0.
- Target duties (L,R) per state:
  - IDLE (0,0); FORWARD (FAST,FAST); LEFT (SLOW,FAST); RIGHT (FAST,SLOW); HALT (0,0).
  - SEARCH with LastTurn=0: (0,SLOW). With LastTurn=1: (SLOW,0).
- Duty registers DutyL/DutyR normally load target duties only when PwmCnt==2^PWM_BITS-1. The new duty takes effect from PwmCnt=0.
- Immediate stop: on the cycle State becomes IDLE or HALT, DutyL/DutyR clear to 0 the same edge, without waiting for the period boundary.
- Duty values are PWM_BITS wide. Parameters above 2^PWM_BITS-1 saturate to all-ones. Duty 0 gives a constant low output.

## Timing
- Reset values: State=0, PwmCnt=0, DutyL=DutyR=0, LostCnt=0, LastTurn=0, Lost=0. Hence LeftPwm=RightPwm=0.
- Reset asserted mid-period: outputs go low immediately (asynchronous). After release, PwmCnt restarts at 0.
- Sensor → State latency: 1 clock.
- State → PWM duty change: takes effect at the next PwmCnt=0, i.e. 1 to 2^PWM_BITS cycles later.
- Stop latency: IDLE/HALT gives PWM low 1 clock after the Sensor/Enable edge.
- PwmCnt free-runs from reset, wrapping 2^PWM_BITS-1 → 0. It is not reset by Enable or state changes.
- LeftPwm/RightPwm are a compare of two registers (PwmCnt and the duty register). Each is high for exactly Duty cycles per period, starting at PwmCnt=0.

## Test plan
Parameters for all scenarios: PWM_BITS=4, DUTY_FAST=12, DUTY_SLOW=4, LOST_CYCLES=20.

- Reset/idle: hold Reset low 5 clocks with Enable=1 and Sensor=010 → all outputs 0. Release → State=1 next clock; both PWMs high 12 of 16 cycles from the next PwmCnt=0.
- Steering: FORWARD, then Sensor=110 mid-period → State=2 next clock. Current period is unchanged; next period LeftPwm high 4 cycles, RightPwm high 12.
- Lost line: LEFT then Sensor=000 held → State=4. In SEARCH, LeftPwm=0 and RightPwm high 4 per period. After 20 SEARCH cycles → State=0, Lost=1, PWMs 0 next clock. Sensor=010 keeps IDLE. Enable low 1 clock then high → FORWARD.
- Recovery race: Sensor=001 on the 20th SEARCH cycle → State=3, Lost stays 0.
- Stop line: Sensor=111 at PwmCnt=5 in FORWARD → State=5 and PWMs low at PwmCnt=6. Sensor=010 ignored. Enable low → IDLE.
- Async reset mid-run: assert Reset at PwmCnt=7 between clock edges → PWMs drop immediately and State=0 without a clock edge.
